word_pack_arb: RTL and testbench
================================

# word_pack_arb

Two-requester byte-to-word packer controller. Accepts 8-bit byte streams from two sources, grants the shared 32-bit packing datapath to one source per word with round-robin arbitration, and assembles bytes MSB-first into a 32-bit word. Short words, terminated early by `last`, are padded in the unfilled lanes. It sits between byte-wide producers and 32-bit consumers and generalizes the fixed `{in1, in2, ZERO}` packing into a sequenced, handshaked, shared resource.

## Interface
- `PAD_BYTE`, default `8'h00`: fill value for every unfilled byte lane of a short word.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s0_valid`  in  1  requester 0 byte valid.
- `s0_data`  in  8  requester 0 byte.
- `s0_last`  in  1  requester 0 byte is last of word.
- `s0_ready`  out  1  requester 0 byte accepted this cycle when high with `s0_valid`.
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready`: same as requester 0, for requester 1.
- `m_valid`  out  1  packed word available.
- `m_data`  out  32  packed word.
- `m_src`  out  1  requester that produced `m_data` (0/1).
- `m_bytes`  out  3  valid byte count in `m_data`, range 1..4.
- `m_ready`  in  1  consumer accepts word.

## Operation
- States: IDLE, COLLECT, EMIT.
- IDLE: both `s*_ready` = 0. If any `s*_valid` = 1, choose a grant.
  - One valid: grant to that requester.
  - Both valid: grant to `rr`; `rr` resets to 0.
  - Latch `grant`, clear `cnt` to 0, preset all lanes of the word register to `PAD_BYTE`, then go to COLLECT.
- COLLECT: `s<grant>_ready` = 1; the other requester's ready = 0 and its valid is ignored.
  - On each handshake, write the byte to lane `cnt`: lane 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Then increment `cnt`.
  - If the handshake has `last` = 1, or `cnt` = 3 before the increment, go to EMIT.
  - Set `m_bytes` = `cnt` + 1.
  - If valid drops mid-word, hold COLLECT indefinitely. There is no timeout.
- EMIT: `m_valid` = 1; both `s*_ready` = 0.
  - On `m_ready` = 1, go to IDLE and set `rr` = ~`grant`.
- Two-byte short word: `m_data` = `{b0, b1, {2{PAD_BYTE}}}`. This is the original hi/lo + zero format when `PAD_BYTE` = 0.
- `last` on the 4th byte behaves the same as a full word. A `last` on any byte ends the word; remaining lanes stay `PAD_BYTE`.

## Timing
- Reset (`rst_n` low at an edge), including mid-word:
  - State returns to IDLE and the partial word is discarded.
  - `m_valid` = 0, `m_data` = 0, `m_src` = 0, `m_bytes` = 0, `s0_ready` = `s1_ready` = 0, `rr` = 0, `cnt` = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `*_valid` or `m_ready` to any ready output.
- Latency, full word with back-to-back bytes:
  - Valid seen in IDLE at cycle 0.
  - Bytes accepted in cycles 1–4.
  - `m_valid` high from cycle 5.
  - IDLE again the cycle after the `m_ready` handshake.
- Minimum 6 cycles per 4-byte word. Minimum 3 cycles per 1-byte word.
- While `m_valid` = 1 and `m_ready` = 0: `m_data`, `m_src` and `m_bytes` are held stable.
- After the EMIT handshake, `m_valid` drops the next cycle. `m_data` retains its last value until the next EMIT.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Test plan
- Reset, then s0 sends 8'h10, 8'h20, 8'h30, 8'h40 (last on 4th) -> `m_data` = 32'h10203040, `m_src` = 0, `m_bytes` = 4, `m_valid` rising in cycle 5.
- s1 sends 8'h10, 8'h20 with last on the 2nd byte, `PAD_BYTE` = 0 -> `m_data` = 32'h10200000, `m_bytes` = 2, `m_src` = 1.
- Both requesters valid continuously, `m_ready` = 1, 4 words of 4 bytes each -> `m_src` sequence 0,1,0,1; the non-granted ready stays 0 throughout.
- Hold `m_ready` = 0 for 5 cycles during EMIT -> `m_data`, `m_src` and `m_bytes` are stable; both `s*_ready` = 0; the word is accepted on the first `m_ready` = 1.
- s0 sends 8'hAA, 8'hBB, then `rst_n` = 0 for one edge -> all outputs return to reset values. The next word 8'hCC (last) yields `m_data` = 32'hCC000000, `m_bytes` = 1.
- s0 valid drops for 3 cycles after the 1st byte of 8'h11, 8'h22, 8'h33, 8'h44 -> controller holds COLLECT; final `m_data` = 32'h11223344.

Source files
------------

// File: rtl/word_pack_arb.sv
// word_pack_arb: round-robin shared byte-to-word packer.
// Ports: s0_*/s1_* byte streams in, m_* 32-bit word stream out.
module word_pack_arb #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  input  logic [7:0]  s0_data,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_data,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_src,
  output logic [2:0]  m_bytes,
  input  logic        m_ready
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  state_t      state;
  logic        grant;
  logic        rr;
  logic [1:0]  cnt;
  logic [31:0] word;

  logic        idle_gnt;
  logic        hs;
  logic [7:0]  bdata;
  logic        blast;
  logic [31:0] word_nx;

  // Contention goes to rr; otherwise whoever is valid.
  assign idle_gnt = (s0_valid && s1_valid) ? rr : s1_valid;

  assign hs = grant ? (s1_valid && s1_ready)
                    : (s0_valid && s0_ready);
  assign bdata = grant ? s1_data : s0_data;
  assign blast = grant ? s1_last : s0_last;

  // Lane 0 is the most significant byte.
  always_comb begin
    word_nx = word;
    unique case (cnt)
      2'd0: word_nx[31:24] = bdata;
      2'd1: word_nx[23:16] = bdata;
      2'd2: word_nx[15:8]  = bdata;
      2'd3: word_nx[7:0]   = bdata;
      default: word_nx = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 1'b0;
      rr       <= 1'b0;
      cnt      <= 2'd0;
      word     <= '0;
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_src    <= 1'b0;
      m_bytes  <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            grant    <= idle_gnt;
            cnt      <= 2'd0;
            word     <= {4{PAD_BYTE}};
            s0_ready <= !idle_gnt;
            s1_ready <= idle_gnt;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (hs) begin
            word <= word_nx;
            cnt  <= cnt + 2'd1;
            if (blast || cnt == 2'd3) begin
              // Output word is only loaded here, so it
              // survives IDLE/COLLECT of the next word.
              s0_ready <= 1'b0;
              s1_ready <= 1'b0;
              m_valid  <= 1'b1;
              m_data   <= word_nx;
              m_src    <= grant;
              m_bytes  <= {1'b0, cnt} + 3'd1;
              state    <= EMIT;
            end
          end
        end
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            rr      <= ~grant;
            state   <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          s0_ready <= 1'b0;
          s1_ready <= 1'b0;
          m_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_pack_arb.sv
// tb_word_pack_arb: directed and random checks of word_pack_arb.
// Inputs change on negedge; outputs are read on negedge.
module tb_word_pack_arb;

  localparam logic [7:0] PAD = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_valid = 1'b0;
  logic [7:0]  s0_data = 8'h00;
  logic        s0_last = 1'b0;
  logic        s0_ready;
  logic        s1_valid = 1'b0;
  logic [7:0]  s1_data = 8'h00;
  logic        s1_last = 1'b0;
  logic        s1_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_src;
  logic [2:0]  m_bytes;
  logic        m_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic        l0[$];
  logic        l1[$];
  logic [31:0] e0[$];
  logic [31:0] e1[$];
  logic [2:0]  eb0[$];
  logic [2:0]  eb1[$];
  logic        srcs[$];

  bit          hold_pend;
  logic [31:0] hold_d;
  logic        hold_s;
  logic [2:0]  hold_b;

  word_pack_arb #(.PAD_BYTE(PAD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s0_valid),
    .s0_data  (s0_data),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_src    (m_src),
    .m_bytes  (m_bytes),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  // Reference packing: first n bytes MSB-first, rest padded.
  function automatic logic [31:0] pack(input logic [31:0] b,
                                       input int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++)
      w = {w[23:0], (i < n) ? b[31-8*i -: 8] : PAD};
    return w;
  endfunction

  task automatic clear_inputs();
    s0_valid = 1'b0;
    s0_last  = 1'b0;
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    m_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic accept();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  // Sends n bytes from src; optional valid gap after byte 0.
  // Returns at the negedge after the final byte handshake.
  task automatic drive_word(input bit src, input int n,
                            input logic [31:0] b, input int gap,
                            input bit with_last);
    int   i = 0;
    int   t = 0;
    int   g = gap;
    logic v;
    logic rdy;
    while (i < n && t < 100) begin
      @(negedge clk);
      t++;
      rdy = src ? s1_ready : s0_ready;
      v = !(i == 1 && g > 0);
      if (!v) g--;
      if (src) begin
        s1_valid = v;
        s1_data  = b[31-8*i -: 8];
        s1_last  = with_last && (i == n - 1);
      end else begin
        s0_valid = v;
        s0_data  = b[31-8*i -: 8];
        s0_last  = with_last && (i == n - 1);
      end
      if (v && rdy) i++;
    end
    @(negedge clk);
    s0_valid = 1'b0;
    s0_last  = 1'b0;
    s1_valid = 1'b0;
    s1_last  = 1'b0;
  endtask

  task automatic push_word(input bit src, input int n);
    logic [31:0] b = $urandom;
    for (int i = 0; i < n; i++) begin
      if (src) begin
        q1.push_back(b[31-8*i -: 8]);
        l1.push_back(i == n - 1);
      end else begin
        q0.push_back(b[31-8*i -: 8]);
        l0.push_back(i == n - 1);
      end
    end
    if (src) begin
      e1.push_back(pack(b, n));
      eb1.push_back(3'(n));
    end else begin
      e0.push_back(pack(b, n));
      eb0.push_back(3'(n));
    end
  endtask

  // One cycle of queue-driven traffic with scoreboard checks.
  task automatic rand_cycle(input int pv0, input int pv1,
                            input int pm);
    logic [31:0] xd;
    logic [2:0]  xb;
    @(negedge clk);
    if (hold_pend) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== hold_d ||
          m_src !== hold_s || m_bytes !== hold_b) begin
        errors++;
        $display("FAIL hold: got v=%b d=%h s=%b n=%0d exp d=%h s=%b n=%0d",
                 m_valid, m_data, m_src, m_bytes,
                 hold_d, hold_s, hold_b);
      end
    end
    checks++;
    if ((s0_ready && s1_ready) ||
        (m_valid && (s0_ready || s1_ready))) begin
      errors++;
      $display("FAIL ready_excl: got r0=%b r1=%b mv=%b exp one-hot, none in emit",
               s0_ready, s1_ready, m_valid);
    end
    s0_valid = (q0.size() > 0) && ($urandom_range(99) < pv0);
    s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    s0_last  = (l0.size() > 0) ? l0[0] : 1'b0;
    s1_valid = (q1.size() > 0) && ($urandom_range(99) < pv1);
    s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    s1_last  = (l1.size() > 0) ? l1[0] : 1'b0;
    m_ready  = ($urandom_range(99) < pm);
    if (s0_valid && s0_ready) begin
      void'(q0.pop_front());
      void'(l0.pop_front());
    end
    if (s1_valid && s1_ready) begin
      void'(q1.pop_front());
      void'(l1.pop_front());
    end
    hold_pend = m_valid && !m_ready;
    hold_d = m_data;
    hold_s = m_src;
    hold_b = m_bytes;
    if (m_valid && m_ready) begin
      srcs.push_back(m_src);
      checks++;
      if ((m_src ? e1.size() : e0.size()) == 0) begin
        errors++;
        $display("FAIL word_unexpected: got src=%b d=%h exp no word",
                 m_src, m_data);
      end else begin
        xd = m_src ? e1.pop_front() : e0.pop_front();
        xb = m_src ? eb1.pop_front() : eb0.pop_front();
        if (m_data !== xd || m_bytes !== xb) begin
          errors++;
          $display("FAIL word_src%0d: got d=%h n=%0d exp d=%h n=%0d",
                   m_src, m_data, m_bytes, xd, xb);
        end
      end
    end
  endtask

  task automatic drain(input int pv, input int pm, input int lim);
    int t = 0;
    hold_pend = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size()) > 0 &&
           t < lim) begin
      rand_cycle(pv, pv, pm);
      t++;
    end
    checks++;
    if (t >= lim) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left exp 0",
               e0.size() + e1.size());
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_data, m_src, m_bytes, s0_ready, s1_ready}
        !== 39'h0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%h s=%b n=%0d r=%b%b exp all 0",
               m_valid, m_data, m_src, m_bytes, s0_ready, s1_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    logic [31:0] b = 32'h10203040;
    @(negedge clk);
    s0_valid = 1'b1;
    s0_data  = 8'h10;
    s0_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (s0_ready !== 1'b1 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL full_collect%0d: got r0=%b mv=%b exp r0=1 mv=0",
                 i, s0_ready, m_valid);
      end
      s0_data = b[31-8*i -: 8];
      s0_last = (i == 3);
    end
    @(negedge clk);
    s0_valid = 1'b0;
    s0_last  = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h10203040 ||
        m_src !== 1'b0 || m_bytes !== 3'd4) begin
      errors++;
      $display("FAIL full_word: got v=%b d=%h s=%b n=%0d exp 1 10203040 0 4",
               m_valid, m_data, m_src, m_bytes);
    end
    accept();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h10203040) begin
      errors++;
      $display("FAIL full_after: got v=%b d=%h exp v=0 d=10203040",
               m_valid, m_data);
    end
  endtask

  task automatic test_short_word();
    drive_word(1'b1, 2, 32'h10200000, 0, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h10200000 ||
        m_src !== 1'b1 || m_bytes !== 3'd2) begin
      errors++;
      $display("FAIL short_word: got v=%b d=%h s=%b n=%0d exp 1 10200000 1 2",
               m_valid, m_data, m_src, m_bytes);
    end
    accept();
  endtask

  task automatic test_backpressure();
    drive_word(1'b0, 4, 32'hA1B2C3D4, 0, 1'b1);
    s1_valid = 1'b1;
    s1_data  = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hA1B2C3D4 ||
          m_src !== 1'b0 || m_bytes !== 3'd4 ||
          s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: got v=%b d=%h s=%b n=%0d r=%b%b exp 1 a1b2c3d4 0 4 00",
                 k, m_valid, m_data, m_src, m_bytes,
                 s0_ready, s1_ready);
      end
    end
    s1_valid = 1'b0;
    accept();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got mv=%b exp 0", m_valid);
    end
  endtask

  task automatic test_valid_gap();
    drive_word(1'b0, 4, 32'h11223344, 3, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h11223344 ||
        m_bytes !== 3'd4) begin
      errors++;
      $display("FAIL valid_gap: got v=%b d=%h n=%0d exp 1 11223344 4",
               m_valid, m_data, m_bytes);
    end
    accept();
  endtask

  task automatic test_reset_midword();
    drive_word(1'b0, 2, 32'hAABB0000, 0, 1'b0);
    checks++;
    if (s0_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_collect: got r0=%b mv=%b exp 1 0",
               s0_ready, m_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({m_valid, m_data, m_src, m_bytes, s0_ready, s1_ready}
        !== 39'h0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h s=%b n=%0d r=%b%b exp all 0",
               m_valid, m_data, m_src, m_bytes, s0_ready, s1_ready);
    end
    drive_word(1'b0, 1, 32'hCC000000, 0, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hCC000000 ||
        m_bytes !== 3'd1 || m_src !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got v=%b d=%h s=%b n=%0d exp 1 cc000000 0 1",
               m_valid, m_data, m_src, m_bytes);
    end
    accept();
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int w = 0; w < 2; w++) begin
      push_word(1'b0, 4);
      push_word(1'b1, 4);
    end
    srcs.delete();
    drain(100, 100, 200);
    checks++;
    if (srcs.size() != 4) begin
      errors++;
      $display("FAIL fair_count: got %0d exp 4", srcs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (srcs[k] !== 1'(k % 2)) begin
          errors++;
          $display("FAIL fair_seq%0d: got %b exp %0d",
                   k, srcs[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 40; w++)
      push_word(1'($urandom_range(1)), $urandom_range(4, 1));
    drain(70, 60, 4000);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_word();
    test_backpressure();
    test_valid_gap();
    test_reset_midword();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
